// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Optional feature macro: ILLEGAL_OP_TRAP_EN (adds the TRAP state).
package mips_ctrl_pkg;

  // Controller states; TRAP exists only when illegal-opcode trapping is built in.
  typedef enum logic [3:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EX,
    S_ADDI_WB
`ifdef ILLEGAL_OP_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALU-op codes consumed by the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Bundle of every datapath control strobe/select
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control decoder for the multi-cycle MIPS controller.
// Outputs are pure Moore decodes except ir_write/pc_write in FETCH, which wait
// for the memory to deliver the instruction (mem_ready).
module multicycle_control_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Decode the current state into datapath controls
  always_comb begin
    // NOTE: every field gets a default before the case so no path infers a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADDI;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      // BOOT (and TRAP when built in) keep every control low
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// next-state logic and retired-instruction counter.
// Optional feature macro: ILLEGAL_OP_TRAP_EN -- unknown opcodes enter a sticky
// TRAP state and raise trap; otherwise they retire as NOPs.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [CNT_W-1:0] instr_retired
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic             trap
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  ctrl_t            ctrl;
`ifdef ILLEGAL_OP_TRAP_EN
  logic             trap_q, trap_d;
`endif

  // Next-state selection; opcode matters only in DECODE and MEM_ADDR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:      state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_BOOT;
    endcase
  end

  // An instruction retires when it hands control back to FETCH
  always_comb begin
    retire = (state_d == S_FETCH) && (state_q != S_BOOT) && (state_q != S_FETCH);
    cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
`ifdef ILLEGAL_OP_TRAP_EN
    trap_d = trap_q | (state_d == S_TRAP);
`endif
  end

  // State, counter and trap flag registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q <= S_BOOT;
      cnt_q   <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef ILLEGAL_OP_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  multicycle_control_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_retired = cnt_q;
`ifdef ILLEGAL_OP_TRAP_EN
  assign trap          = trap_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (CNT_W=4 so the counter wraps quickly).
// The driver pushes the expected control word per cycle; a monitor compares on
// the falling edge. Build with or without ILLEGAL_OP_TRAP_EN.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_RT   = 6'b000000;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_BAD  = 6'b111111;

  typedef enum int {
    X_BOOT, X_FETCH, X_DECODE, X_MEM_ADDR, X_MEM_READ, X_MEM_WB, X_MEM_WRITE,
    X_EXECUTE, X_R_WB, X_BRANCH, X_JUMP, X_ADDI_EX, X_ADDI_WB, X_TRAP
  } tst_e;

  typedef struct {
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] ret;
    logic             trap;
    int               tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic [CNT_W-1:0] instr_retired;
  logic             trap;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [CNT_W-1:0] r_exp = '0;
  logic             trap_exp = 1'b0;
  int               tag = 0;
  int               checks = 0;
  int               errors = 0;
  logic [15:0]      act_ctrl;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_retired (instr_retired)
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    .trap          (trap)
`endif
  );

`ifndef ILLEGAL_OP_TRAP_EN
  assign trap = 1'b0;
`endif

  assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  // Expected control word per state, written straight from the state table
  function automatic logic [15:0] exp_ctrl(input tst_e s, input logic rdy);
    logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, op, ps;
    {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      X_FETCH:     begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
      X_DECODE:    sb = 2'b11;
      X_MEM_ADDR:  begin sa = 1'b1; sb = 2'b10; end
      X_MEM_READ:  begin mr = 1'b1; iord = 1'b1; end
      X_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      X_MEM_WRITE: begin mw = 1'b1; iord = 1'b1; end
      X_EXECUTE:   begin sa = 1'b1; op = 2'b10; end
      X_R_WB:      begin rw = 1'b1; rd = 1'b1; end
      X_BRANCH:    begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
      X_JUMP:      begin pw = 1'b1; ps = 2'b10; end
      X_ADDI_EX:   begin sa = 1'b1; sb = 2'b10; op = 2'b11; end
      X_ADDI_WB:   rw = 1'b1;
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
  endfunction

  task automatic check(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  // One clock of stimulus plus the expected response for that cycle
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic rst, input tst_e s);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    reset     = rst;
    e.ctrl = exp_ctrl(s, rdy);
    e.ret  = r_exp;
    e.trap = trap_exp;
    e.tag  = tag;
    tag++;
    exp_q.push_back(e);
  endtask

  task automatic do_j();
    cyc(T_J, 1'b1, 1'b0, X_FETCH);
    cyc(T_J, 1'b0, 1'b0, X_DECODE);
    cyc(T_J, 1'b0, 1'b0, X_JUMP);
    r_exp++;
  endtask

  // Monitor: compare whatever the DUT shows against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ctrl", mon_e.tag, 32'(act_ctrl), 32'(mon_e.ctrl));
        check("instr_retired", mon_e.tag, 32'(instr_retired), 32'(mon_e.ret));
`ifdef ILLEGAL_OP_TRAP_EN
        check("trap", mon_e.tag, 32'(trap), 32'(mon_e.trap));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver: directed instruction sequences
  initial begin
    reset = 1'b1; opcode = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    cyc(T_RT, 1'b1, 1'b0, X_BOOT);

    // lw behind two FETCH wait cycles; mem_ready low in MEM_WB is ignored
    cyc(T_LW, 1'b0, 1'b0, X_FETCH);
    cyc(T_LW, 1'b0, 1'b0, X_FETCH);
    cyc(T_LW, 1'b1, 1'b0, X_FETCH);
    cyc(T_LW, 1'b1, 1'b0, X_DECODE);
    cyc(T_LW, 1'b1, 1'b0, X_MEM_ADDR);
    cyc(T_LW, 1'b1, 1'b0, X_MEM_READ);
    cyc(T_LW, 1'b0, 1'b0, X_MEM_WB);
    r_exp++;

    // sw with three memory wait states
    cyc(T_SW, 1'b1, 1'b0, X_FETCH);
    cyc(T_SW, 1'b1, 1'b0, X_DECODE);
    cyc(T_SW, 1'b1, 1'b0, X_MEM_ADDR);
    cyc(T_SW, 1'b0, 1'b0, X_MEM_WRITE);
    cyc(T_SW, 1'b0, 1'b0, X_MEM_WRITE);
    cyc(T_SW, 1'b0, 1'b0, X_MEM_WRITE);
    cyc(T_SW, 1'b1, 1'b0, X_MEM_WRITE);
    r_exp++;

    // R-type; opcode changes after DECODE must not matter
    cyc(T_RT, 1'b1, 1'b0, X_FETCH);
    cyc(T_RT, 1'b1, 1'b0, X_DECODE);
    cyc(T_LW, 1'b1, 1'b0, X_EXECUTE);
    cyc(T_SW, 1'b1, 1'b0, X_R_WB);
    r_exp++;

    // beq
    cyc(T_BEQ, 1'b1, 1'b0, X_FETCH);
    cyc(T_BEQ, 1'b1, 1'b0, X_DECODE);
    cyc(T_BEQ, 1'b1, 1'b0, X_BRANCH);
    r_exp++;

    // addi
    cyc(T_ADDI, 1'b1, 1'b0, X_FETCH);
    cyc(T_ADDI, 1'b1, 1'b0, X_DECODE);
    cyc(T_ADDI, 1'b1, 1'b0, X_ADDI_EX);
    cyc(T_ADDI, 1'b1, 1'b0, X_ADDI_WB);
    r_exp++;

    // 11 jumps take the count from 5 to 16, i.e. wrap to 0; one more gives 1
    for (int i = 0; i < 12; i++) do_j();

    // Reset held three cycles starting mid-EXECUTE
    cyc(T_RT, 1'b1, 1'b0, X_FETCH);
    cyc(T_RT, 1'b1, 1'b0, X_DECODE);
    cyc(T_RT, 1'b1, 1'b1, X_EXECUTE);
    r_exp = '0;
    cyc(T_RT, 1'b1, 1'b1, X_BOOT);
    cyc(T_RT, 1'b1, 1'b1, X_BOOT);
    cyc(T_RT, 1'b1, 1'b0, X_BOOT);
    do_j();

    // Unknown opcode
    cyc(T_BAD, 1'b1, 1'b0, X_FETCH);
    cyc(T_BAD, 1'b1, 1'b0, X_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
    trap_exp = 1'b1;
    cyc(T_J, 1'b1, 1'b0, X_TRAP);
    cyc(T_LW, 1'b0, 1'b0, X_TRAP);
    cyc(T_RT, 1'b1, 1'b0, X_TRAP);
    cyc(T_BAD, 1'b1, 1'b0, X_TRAP);
`else
    r_exp++;
    do_j();
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", tag, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
